// File: rtl/mc_fetch_unit.sv
// mc_fetch_unit: PC / IR / MDR / ALUOut register stage of the multicycle MIPS datapath.
// Optional PC alignment trap is built when the macro PC_ALIGN_CHECK_EN is defined.
module mc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcwrite,
  input  logic        branch,
  input  logic        zero,
  input  logic [1:0]  pcsrc,
  input  logic        IorD,
  input  logic        IRwrite,
  input  logic [31:0] aluresult,
  input  logic [31:0] readdata,
  output logic [31:0] adr,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] data,
  output logic [31:0] aluout,
  output logic [31:0] pc,
  output logic        pcen,
  output logic [31:0] icount,
  output logic        misalign
);

  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] data_r;
  logic [31:0] aluout_r;
  logic [31:0] icount_r;
  logic [31:0] jump_target_s;
  logic [31:0] pc_src_s;
  logic        pcen_s;
  logic        pc_sel_ok_s;
  logic        pc_load_s;

  // Effective PC enable and next-PC source; the jump target uses the pre-edge pc/instr
  always_comb begin
    pcen_s        = pcwrite | (branch & zero);
    jump_target_s = {pc_r[31:28], instr_r[25:0], 2'b00};
    pc_src_s      = pc_r;
    pc_sel_ok_s   = 1'b0;
    case (pcsrc)
      2'b00: begin
        pc_src_s    = aluresult;
        pc_sel_ok_s = 1'b1;
      end
      2'b01: begin
        pc_src_s    = aluout_r;
        pc_sel_ok_s = 1'b1;
      end
      2'b10: begin
        pc_src_s    = jump_target_s;
        pc_sel_ok_s = 1'b1;
      end
      default: begin
        pc_src_s    = pc_r;
        pc_sel_ok_s = 1'b0;
      end
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_r;
  logic bad_align_s;

  // Alignment screen: a misaligned load, or any load after a trap, never reaches pc
  always_comb begin
    bad_align_s = (pc_src_s[1:0] != 2'b00);
    if (misalign_r || bad_align_s) begin
      pc_load_s = 1'b0;
    end else begin
      pc_load_s = pcen_s & pc_sel_ok_s;
    end
  end

  // Sticky trap flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_r <= 1'b0;
    end else if (pcen_s && pc_sel_ok_s && bad_align_s) begin
      misalign_r <= 1'b1;
    end else begin
      misalign_r <= misalign_r;
    end
  end

  assign misalign = misalign_r;
`else
  // Without the trap every selected, enabled load is taken
  always_comb begin
    pc_load_s = pcen_s & pc_sel_ok_s;
  end

  assign misalign = 1'b0;
`endif

  // Architectural registers; reset overrides every enable
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r     <= RESET_PC;
      instr_r  <= 32'h0000_0000;
      data_r   <= 32'h0000_0000;
      aluout_r <= 32'h0000_0000;
      icount_r <= 32'h0000_0000;
    end else begin
      if (pc_load_s) begin
        pc_r <= pc_src_s;
      end
      if (IRwrite) begin
        instr_r  <= readdata;
        icount_r <= icount_r + 32'd1;
      end
      data_r   <= readdata;
      aluout_r <= aluresult;
    end
  end

  assign adr    = IorD ? aluout_r : pc_r;
  assign instr  = instr_r;
  assign op     = instr_r[31:26];
  assign funct  = instr_r[5:0];
  assign data   = data_r;
  assign aluout = aluout_r;
  assign pc     = pc_r;
  assign pcen   = pcen_s;
  assign icount = icount_r;

endmodule

// File: doc/mc_fetch_unit.md
# mc_fetch_unit

Sequential instruction-side register stage of the multicycle MIPS datapath, sitting directly downstream of the main decoder FSM. It consumes the decoder's per-cycle controls (pcwrite, branch, pcsrc, IorD, IRwrite) together with the ALU result and zero flag. It owns the PC, instruction register (IR), memory data register (MDR) and ALUOut register, drives the unified memory address, and returns op/funct to the decoder.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- clk  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset.
- pcwrite  in  1  unconditional PC write enable.
- branch  in  1  conditional PC write, qualified by zero.
- zero  in  1  ALU zero flag, same cycle.
- pcsrc  in  2  next-PC select: 00 aluresult, 01 aluout, 10 jump target, 11 reserved.
- IorD  in  1  address select: 0 PC, 1 ALUOut.
- IRwrite  in  1  IR load enable.
- aluresult  in  32  combinational ALU result.
- readdata  in  32  memory read data, valid in the same cycle as adr.
- adr  out  32  memory address.
- instr  out  32  IR contents.
- op  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- data  out  32  MDR contents.
- aluout  out  32  ALUOut register.
- pc  out  32  current PC.
- pcen  out  1  effective PC enable.
- icount  out  32  count of IR loads since reset.
- misalign  out  1  sticky misaligned-PC flag; see Configuration.

## Operation
- pcen = pcwrite | (branch & zero), combinational.
- Jump target = {pc[31:28], instr[25:0], 2'b00}. It uses the current pc, which already holds PC+4 after fetch.
- PC update: when pcen=1 and pcsrc≠11, pc ← selected source. pcsrc=11 holds pc regardless of pcen.
- adr = IorD ? aluout : pc, combinational.
- IR: instr ← readdata when IRwrite=1, otherwise held.
- MDR: data ← readdata every cycle, unconditionally.
- ALUOut: aluout ← aluresult every cycle, unconditionally.
- icount: +1 on every cycle with IRwrite=1. 32-bit, wraps FFFF_FFFF→0 silently.
- Simultaneous IRwrite and pcwrite (fetch cycle): IR captures readdata addressed by the old pc, and pc takes the new value. Both update on the same edge.
- Simultaneous IRwrite and pcsrc=10: the jump target is built from the old instr.
- branch=1 with zero=0 and pcwrite=0: PC unchanged.
- Reset values: pc=RESET_PC, instr=0, data=0, aluout=0, icount=0, misalign=0. Derived outputs therefore reset to op=0, funct=0, adr=RESET_PC when IorD=0.
- Reset mid-instruction: all registers take their reset values on that edge, and the in-flight controls are ignored. Reset has priority over every enable.

## Timing
- All state updates on the rising edge of clk. Register update latency is 1 cycle.
- adr, op, funct and pcen are combinational from registers and inputs, with no added latency.
- Memory is combinational read: readdata for adr must settle within the same cycle.
- The decoder sees a new op in the cycle after IRwrite.
- A load's data is available on data in the cycle after the IorD=1 access cycle.
- No handshake and no stall: every control input is honoured in the cycle it is presented.

## Configuration
- PC_ALIGN_CHECK_EN, defined:
  - Any PC load whose value has [1:0]≠00 is suppressed; pc holds.
  - misalign is set on that edge and stays 1 until reset.
  - While misalign=1, all further PC loads are suppressed.
- PC_ALIGN_CHECK_EN, undefined:
  - misalign is tied to 0.
  - PC loads any value, including misaligned ones.

## Test plan
- Reset, then fetch with pcwrite=1, IRwrite=1, pcsrc=00, aluresult=4, readdata=32'h2008_0005 -> pc=4, instr=32'h2008_0005, op=6'b001000, icount=1.
- Beq taken: branch=1, zero=1, pcsrc=01, aluout preloaded 32'h40 -> pcen=1, pc=32'h40. Repeat with zero=0 -> pc unchanged, pcen=0.
- Jump: pc=32'h1000_0004, instr=32'h0800_0010, pcsrc=10, pcwrite=1 -> pc=32'h1000_0040.
- Load path: aluresult=32'h80 (aluout=32'h80 next cycle), then IorD=1 -> adr=32'h80. Next cycle data = readdata from that cycle.
- Reset asserted mid-decode with pcwrite=1 -> pc=RESET_PC, instr=0, icount=0.
- PC_ALIGN_CHECK_EN defined, pcwrite=1, aluresult=32'h6 -> pc holds, misalign=1. A following aligned load is also suppressed until reset.
